// File: rtl/softmax_max_buffer.sv
// Purpose : collect one vector of INPUTMAX IEEE-754 singles, track the maximum,
//           then replay the vector paired with the sign-flipped maximum.
// Latency : OutValid rises the cycle after the last element is accepted.
// Backpressure: input and output phases are exclusive. InReady=0 while
//           replaying. Outputs hold stable while OutValid && !OutReady.
//
// Ports
//   Clock    : rising-edge clock
//   Reset    : synchronous, active-high
//   Datain   : input score, qualified by InValid
//   InValid  : Datain valid
//   InReady  : block can accept input (low only while replaying)
//   OutReady : downstream accepts the current output word
//   OutValid : DataOut / NegMax / Last are valid
//   DataOut  : buffered element, in arrival order
//   NegMax   : vector maximum with its sign bit inverted
//   Last     : current output is the final element of the vector
module softmax_max_buffer #(
    parameter int DATALENGTH = 32,
    parameter int INPUTMAX   = 5
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [DATALENGTH-1:0] Datain,
    input  logic                  InValid,
    output logic                  InReady,
    input  logic                  OutReady,
    output logic                  OutValid,
    output logic [DATALENGTH-1:0] DataOut,
    output logic [DATALENGTH-1:0] NegMax,
    output logic                  Last
);

    // Counters reach INPUTMAX after the final increment, so they carry one
    // extra code beyond the last element index.
    localparam int CW = $clog2(INPUTMAX + 1);
    localparam int AW = (INPUTMAX > 1) ? $clog2(INPUTMAX) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(INPUTMAX - 1);
    localparam logic [CW-1:0] ONE      = CW'(1);
    localparam int MSB = DATALENGTH - 1;

    typedef enum logic [1:0] {
        IDLE        = 2'b00,
        INPUTSTREAM = 2'b01,
        OP          = 2'b10
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [CW-1:0]         wr;
    logic [CW-1:0]         rd;
    logic [DATALENGTH-1:0] mx;
    logic [DATALENGTH-1:0] mem [INPUTMAX];

    logic                  in_fire;
    logic                  out_fire;
    logic [AW-1:0]         wr_idx;
    logic [AW-1:0]         rd_idx;
    logic                  new_is_larger;

    // Map a float onto an unsigned key whose natural order is the IEEE total
    // order: negatives are bit-inverted (larger magnitude -> smaller key),
    // positives get the sign bit set so they sort above every negative.
    // This places -0 just below +0. NaNs are ordered by the same rule.
    function automatic logic [DATALENGTH-1:0] order_key(input logic [DATALENGTH-1:0] x);
        logic [DATALENGTH-1:0] sign_mask;
        sign_mask = {1'b1, {(DATALENGTH-1){1'b0}}};
        return x[MSB] ? ~x : (x ^ sign_mask);
    endfunction

    // Transfers are qualified from state directly rather than from the
    // InReady/OutValid outputs, keeping the decode loop-free.
    assign in_fire  = InValid && (state != OP);
    assign out_fire = OutReady && (state == OP);

    // The first element of a vector always lands in slot 0, independent of
    // whatever wr held before.
    assign wr_idx = (state == IDLE) ? '0 : wr[AW-1:0];
    assign rd_idx = rd[AW-1:0];

    // Strict compare: on a tie the earlier value stays in mx.
    assign new_is_larger = order_key(Datain) > order_key(mx);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and handshake decode
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        InReady   = 1'b1;
        OutValid  = 1'b0;
        unique case (state)
            IDLE: begin
                if (in_fire) begin
                    state_nxt = INPUTSTREAM;
                end
            end
            INPUTSTREAM: begin
                if (in_fire && (wr == LAST_IDX)) begin
                    state_nxt = OP;
                end
            end
            OP: begin
                InReady  = 1'b0;
                OutValid = 1'b1;
                if (out_fire && (rd == LAST_IDX)) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Counters and running maximum
    // ------------------------------------------------------------------
    always_ff @(posedge Clock) begin
        if (Reset) begin
            wr <= '0;
            rd <= '0;
            mx <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_fire) begin
                        mx <= Datain;
                        wr <= ONE;
                    end
                end
                INPUTSTREAM: begin
                    if (in_fire) begin
                        if (new_is_larger) begin
                            mx <= Datain;
                        end
                        wr <= wr + ONE;
                        if (wr == LAST_IDX) begin
                            rd <= '0;
                        end
                    end
                end
                OP: begin
                    if (out_fire) begin
                        rd <= rd + ONE;
                        if (rd == LAST_IDX) begin
                            wr <= '0;
                        end
                    end
                end
                default: begin
                    wr <= '0;
                    rd <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Element storage. Contents are meaningless outside a vector, so the
    // array carries no reset.
    // ------------------------------------------------------------------
    always_ff @(posedge Clock) begin
        if (in_fire) begin
            mem[wr_idx] <= Datain;
        end
    end

    // ------------------------------------------------------------------
    // Output decode. Outputs depend only on registered state, so they hold
    // naturally during a stall and are forced to zero when not valid.
    // ------------------------------------------------------------------
    always_comb begin
        DataOut = '0;
        NegMax  = '0;
        Last    = 1'b0;
        if (state == OP) begin
            DataOut = mem[rd_idx];
            NegMax  = {~mx[MSB], mx[MSB-1:0]};
            Last    = (rd == LAST_IDX);
        end
    end

endmodule

// File: tb/tb_softmax_max_buffer.sv
// Purpose : randomized and directed stimulus for softmax_max_buffer, checked
//           by a queue scoreboard fed from a plain-arithmetic reference model.
// Latency/backpressure of the bench itself are irrelevant; it terminates alone.
module tb_softmax_max_buffer;

    localparam int N = 5;

    logic        Clock;
    logic        Reset;
    logic [31:0] Datain;
    logic        InValid;
    logic        InReady;
    logic        OutReady;
    logic        OutValid;
    logic [31:0] DataOut;
    logic [31:0] NegMax;
    logic        Last;

    softmax_max_buffer #(
        .DATALENGTH (32),
        .INPUTMAX   (N)
    ) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Datain   (Datain),
        .InValid  (InValid),
        .InReady  (InReady),
        .OutReady (OutReady),
        .OutValid (OutValid),
        .DataOut  (DataOut),
        .NegMax   (NegMax),
        .Last     (Last)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] negmax;
        logic        last;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] cur_vec[$];
    logic [31:0] vec [N];
    logic [31:0] pool [6];
    logic [8:0]  bp_pat;

    int n_checks     = 0;
    int n_fail       = 0;
    int cyc          = 0;
    int last_acc_cyc = -100;
    int out_count    = 0;
    int ready_mode   = 0;
    int ready_ph     = 0;
    bit          nm_check_en = 1'b0;
    logic [31:0] nm_expect   = 32'h0;

    always @(posedge Clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // a lies strictly above b in IEEE total order (sign first, then magnitude).
    function automatic bit above(input logic [31:0] a, input logic [31:0] b);
        if (a[31] != b[31]) return b[31];
        if (!a[31]) return a[30:0] > b[30:0];
        return a[30:0] < b[30:0];
    endfunction

    // Reference model: every accepted word is queued; on a full vector the
    // expected replay is pushed onto the scoreboard.
    task automatic model_accept(input logic [31:0] w);
        logic [31:0] m;
        exp_t        e;
        cur_vec.push_back(w);
        if (cur_vec.size() == N) begin
            m = cur_vec[0];
            for (int i = 1; i < N; i++) begin
                if (above(cur_vec[i], m)) m = cur_vec[i];
            end
            for (int i = 0; i < N; i++) begin
                e.data   = cur_vec[i];
                e.negmax = {~m[31], m[30:0]};
                e.last   = (i == N - 1);
                exp_q.push_back(e);
            end
            cur_vec.delete();
        end
    endtask

    // bubble: 0 contiguous, 1 valid pattern 1,0,0,..., 2 random
    task automatic send_vec(input int bubble);
        int idx   = 0;
        int t     = 0;
        int guard = 0;
        while (idx < N && guard < 200) begin
            @(posedge Clock); #1;
            guard++;
            case (bubble)
                0:       InValid = 1'b1;
                1:       InValid = (t % 3 == 0);
                default: InValid = ($urandom_range(0, 1) == 1);
            endcase
            t++;
            Datain = InValid ? vec[idx] : $urandom();
            @(negedge Clock);
            if (InValid && InReady) begin
                model_accept(Datain);
                last_acc_cyc = cyc;
                idx++;
            end
        end
        chk("send_complete", idx, N);
    endtask

    // Keep presenting junk while the block is replaying; it must be ignored.
    task automatic drain();
        int guard = 0;
        while (guard < 300) begin
            @(posedge Clock); #1;
            guard++;
            if (InReady) begin
                InValid = 1'b0;
                break;
            end
            InValid = 1'b1;
            Datain  = $urandom();
        end
        chk("drain_inready", InReady, 1);
        chk("drain_queue_empty", exp_q.size(), 0);
    endtask

    // Downstream ready generator
    initial begin
        OutReady = 1'b0;
        forever begin
            @(posedge Clock); #1;
            case (ready_mode)
                0: OutReady = 1'b1;
                1: begin
                    if (OutValid) begin
                        OutReady = bp_pat[ready_ph];
                        ready_ph = (ready_ph + 1) % 9;
                    end else begin
                        OutReady = 1'b0;
                    end
                end
                default: OutReady = ($urandom_range(0, 2) != 0);
            endcase
        end
    end

    // Monitor / scoreboard
    logic        p_vld = 1'b0;
    logic        p_fire = 1'b0;
    logic        p_last_fire = 1'b0;
    logic        p_rst = 1'b1;
    logic [31:0] p_d = 32'h0;
    logic [31:0] p_nm = 32'h0;
    logic        p_l = 1'b0;
    exp_t        mon_e;

    initial begin
        forever begin
            @(negedge Clock);
            if (!p_rst) begin
                chk("inready_vs_outvalid", InReady, !OutValid);
            end
            if (OutValid !== 1'b1) begin
                chk("idle_dataout", DataOut, 32'h0);
                chk("idle_negmax", NegMax, 32'h0);
                chk("idle_last", Last, 1'b0);
            end
            if (p_vld && !p_fire && !p_rst && !Reset) begin
                chk("stall_outvalid", OutValid, 1'b1);
                chk("stall_dataout", DataOut, p_d);
                chk("stall_negmax", NegMax, p_nm);
                chk("stall_last", Last, p_l);
            end
            if (p_last_fire && !p_rst) begin
                chk("after_last_inready", InReady, 1'b1);
                chk("after_last_outvalid", OutValid, 1'b0);
            end
            if (OutValid && !p_vld && !Reset) begin
                chk("outvalid_latency", cyc - last_acc_cyc, 1);
            end
            if (OutValid && OutReady && !Reset) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", DataOut, 32'hxxxxxxxx);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("dataout", DataOut, mon_e.data);
                    chk("negmax", NegMax, mon_e.negmax);
                    chk("last", Last, mon_e.last);
                    if (nm_check_en) chk("negmax_directed", NegMax, nm_expect);
                end
                out_count++;
            end
            p_vld       = OutValid;
            p_fire      = OutValid && OutReady && !Reset;
            p_last_fire = p_fire && Last;
            p_rst       = Reset;
            p_d         = DataOut;
            p_nm        = NegMax;
            p_l         = Last;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic reset_checks(input string tag);
        chk({tag, "_inready"}, InReady, 1'b1);
        chk({tag, "_outvalid"}, OutValid, 1'b0);
        chk({tag, "_dataout"}, DataOut, 32'h0);
        chk({tag, "_negmax"}, NegMax, 32'h0);
        chk({tag, "_last"}, Last, 1'b0);
    endtask

    initial begin
        int target;
        int guard;
        bp_pat  = 9'b110110100;   // bit i = ready on i-th valid cycle: 0,0,1,0,1,1,0,1,1
        pool    = '{32'h00000000, 32'h80000000, 32'h3f800000,
                    32'hbf800000, 32'h7f800000, 32'hff800000};
        Reset   = 1'b1;
        InValid = 1'b0;
        Datain  = 32'h0;

        repeat (2) @(posedge Clock);
        @(negedge Clock);
        reset_checks("in_reset");
        @(posedge Clock); #1;
        Reset = 1'b0;
        @(negedge Clock);
        reset_checks("after_reset");

        // Basic vector
        nm_check_en = 1'b1;
        nm_expect   = 32'hc0a00000;
        vec = '{32'h3f800000, 32'h40000000, 32'hc0400000, 32'h3f000000, 32'h40a00000};
        send_vec(0);
        drain();

        // All-negative vector
        nm_expect = 32'h3f000000;
        vec = '{32'hbf800000, 32'hc0400000, 32'hbf000000, 32'hc0000000, 32'hc0800000};
        send_vec(0);
        drain();

        // Signed zero and ties
        nm_expect = 32'h80000000;
        vec = '{32'h80000000, 32'h00000000, 32'hbf800000, 32'h00000000, 32'hc0000000};
        send_vec(0);
        drain();
        nm_check_en = 1'b0;

        // Input bubbles; junk offered during replay by drain()
        vec = '{32'h41200000, 32'hc1200000, 32'h3e800000, 32'h42c80000, 32'h00000001};
        send_vec(1);
        drain();

        // Backpressure pattern
        ready_ph   = 0;
        ready_mode = 1;
        vec = '{32'h3f800000, 32'h40400000, 32'h40000000, 32'hbf800000, 32'h3f000000};
        send_vec(0);
        drain();
        ready_mode = 0;

        // Reset mid-replay, then a fresh vector
        vec = '{32'h40e00000, 32'h41000000, 32'h3f800000, 32'h40000000, 32'h40400000};
        send_vec(0);
        target = out_count + 2;
        guard  = 0;
        while (out_count < target && guard < 100) begin
            @(posedge Clock); #1;
            guard++;
        end
        chk("two_outputs_before_reset", out_count, target);
        Reset   = 1'b1;
        InValid = 1'b0;
        exp_q.delete();
        cur_vec.delete();
        @(posedge Clock); #1;
        Reset = 1'b0;
        @(negedge Clock);
        reset_checks("mid_op_reset");
        nm_check_en = 1'b1;
        nm_expect   = 32'hc0400000;
        vec = '{32'h3f800000, 32'h40400000, 32'hc1200000, 32'h40000000, 32'h00000000};
        send_vec(0);
        drain();
        nm_check_en = 1'b0;

        // Randomized vectors with random bubbles and random downstream ready
        ready_mode = 2;
        for (int v = 0; v < 20; v++) begin
            for (int i = 0; i < N; i++) begin
                vec[i] = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 5)] : $urandom();
            end
            send_vec(2);
            drain();
        end
        ready_mode = 0;

        repeat (3) @(posedge Clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/softmax_max_buffer.md
# softmax_max_buffer

Upstream stage of the softmax datapath, directly feeding `exponential`. Collects one vector of `INPUTMAX` IEEE-754 single-precision scores and tracks their maximum. It then replays the vector element by element, each element paired with the negated maximum. The downstream adder forms `x - max` from this pair, so every input to `exponential` is ≤ 0.

## Interface
Parameters:
- `DATALENGTH`, 32, word width (IEEE-754 single; only 32 supported)
- `INPUTMAX`, 5, elements per vector (≥ 2)

Ports:
- `Clock`  in  1  sole clock, rising edge
- `Reset`  in  1  synchronous, active-high reset
- `Datain`  in  `DATALENGTH`  input score
- `InValid`  in  1  `Datain` valid
- `InReady`  out  1  block can accept input
- `OutReady`  in  1  downstream accepts output
- `OutValid`  out  1  `DataOut`/`NegMax` valid
- `DataOut`  out  `DATALENGTH`  buffered element, in arrival order
- `NegMax`  out  `DATALENGTH`  vector maximum with sign bit inverted
- `Last`  out  1  current output is element `INPUTMAX-1`

## Operation
- Internal storage:
  - buffer of `INPUTMAX` words
  - write counter `wr`
  - read counter `rd`
  - max register `mx`
- Input transfer: `InValid && InReady` on a rising edge. Output transfer: `OutValid && OutReady`.
- FSM states: IDLE (2'b00), INPUTSTREAM (2'b01), OP (2'b10).
- IDLE:
  - `InReady`=1.
  - On input transfer: `buf[0]`←`Datain`, `mx`←`Datain`, `wr`←1, go to INPUTSTREAM.
- INPUTSTREAM:
  - `InReady`=1.
  - On input transfer: `buf[wr]`←`Datain`, `mx`←max(`mx`,`Datain`), `wr`++.
  - If the accepted word is element `INPUTMAX-1`: `rd`←0, go to OP.
  - Cycles without `InValid` hold all state.
- OP:
  - `InReady`=0; input is ignored.
  - `OutValid`=1, `DataOut`=`buf[rd]`, `NegMax`={~`mx[31]`, `mx[30:0]`}, `Last`=(`rd`==`INPUTMAX-1`).
  - On output transfer: `rd`++.
  - On the transfer with `Last`=1: `wr`←0, go to IDLE.
- Max ordering:
  - Compare by key = `x[31]` ? ~`x` : `x` ^ 32'h80000000, as an unsigned comparison.
  - This gives total IEEE order, with -0 < +0. NaN is not guarded; it is ordered by the same key.
  - On a tie, `mx` keeps the earlier value.
- When `OutValid`=0, `DataOut`, `NegMax` and `Last` are driven to 0.
- `InReady` is decoded from state (state != OP).
- `OutValid`, `DataOut`, `NegMax` and `Last` are decoded from the state, `rd`, the buffer and `mx`.
- No combinational path from `InValid` to any output, or from `OutReady` to any output.

## Timing
- Reset:
  - Takes effect at the first rising edge with `Reset`=1. State←IDLE, `wr`=`rd`=0, `mx`=0.
  - Buffer contents are don't-care.
  - Output values while in reset and after it: `InReady`=1, `OutValid`=0, `DataOut`=0, `NegMax`=0, `Last`=0.
- Reset asserted mid-vector or mid-OP aborts the vector. No partial output follows.
- Latency: `OutValid` rises in the cycle after the edge that accepted element `INPUTMAX-1`.
- Throughput:
  - With `InValid` and `OutReady` held at 1, one vector takes `2*INPUTMAX` cycles.
  - Input and output phases never overlap.
- Backpressure: while `OutValid && !OutReady`, `DataOut`, `NegMax` and `Last` hold stable.
- After the final output transfer, `InReady`=1 in the next cycle. A new vector can start there.
- `OutValid` never drops without a transfer, except on reset.

## Test plan
- Basic vector:
  - Stimulus: inputs 3f800000, 40000000, c0400000, 3f000000, 40a00000, contiguous; `OutReady`=1.
  - Required: `OutValid` in the cycle after the 5th accept. `DataOut` replays the same five words in order. `NegMax`=c0a00000 on every output. `Last` only on the 5th output.
- All-negative vector:
  - Stimulus: bf800000, c0400000, bf000000, c0000000, c0800000.
  - Required: `NegMax`=3f000000.
- Signed zero and ties:
  - Stimulus: 80000000, 00000000, bf800000, 00000000, c0000000.
  - Required: `NegMax`=80000000.
- Input bubbles:
  - Stimulus: `InValid` toggled 1,0,0,1,… across 5 elements.
  - Required: only accepted words are stored. OP is entered exactly after the 5th accept. Words presented during OP are ignored.
- Backpressure:
  - Stimulus: `OutReady` pattern 0,0,1,0,1,1,0,1,1.
  - Required: outputs are stable while stalled. Exactly 5 transfers occur in order. `InReady`=0 until the cycle after the `Last` transfer.
- Reset mid-OP:
  - Stimulus: assert `Reset` for 1 cycle after 2 output transfers, then send a new vector (max 40400000).
  - Required: `OutValid`=0 and `InReady`=1 after reset. The new vector is replayed with `NegMax`=c0400000 and no stale elements.
